gpi_periph: RTL and testbench

GPI_PERIPH -- requirements
Module: gpi_periph

---
 rtl/gpi_periph.sv | 235 +++++++++++++++++++++++
 tb/tb_gpi_periph.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpi_periph.sv
// -----------------------------------------------------------------------------
// gpi_periph -- APB general-purpose input block with edge interrupts.
//
// Samples WIDTH asynchronous input pins through a two-flop synchronizer, keeps
// one extra history flop for edge detection, and latches enabled rising and
// falling edges into a sticky interrupt status register (ISR). Software reads
// the pins and the status and clears ISR bits through a small APB slave. Every
// transfer is stretched by exactly one wait state.
//
// Register map (PADDR[3:2], WIDTH bits each, zero-extended to 32 on read):
//   0x0 IDR      RO    synchronized pin values
//   0x4 RISE_EN  RW    per-pin rising-edge interrupt enable
//   0x8 FALL_EN  RW    per-pin falling-edge interrupt enable
//   0xC ISR      W1C   sticky edge status; a write of 1 clears that bit
//
// Ports:
//   PCLK     in   1      clock, all state changes on the rising edge
//   PRESET   in   1      asynchronous active-low reset
//   PADDR    in   32     APB address, only bits [3:2] decoded
//   PWDATA   in   32     APB write data, bits above WIDTH-1 ignored
//   PWRITE   in   1      1 = write, 0 = read
//   PENABLE  in   1      APB access-phase marker
//   PSEL     in   1      slave select
//   PRDATA   out  32     registered read data, valid while PREADY = 1
//   PREADY   out  1      registered transfer-complete, high for one cycle
//   inPort   in   WIDTH  asynchronous external pins
//   irq      out  1      level interrupt, OR of all ISR bits
// -----------------------------------------------------------------------------
module gpi_periph #(
  parameter int WIDTH = 8
) (
  input  logic             PCLK,
  input  logic             PRESET,
  input  logic [31:0]      PADDR,
  input  logic [31:0]      PWDATA,
  input  logic             PWRITE,
  input  logic             PENABLE,
  input  logic             PSEL,
  output logic [31:0]      PRDATA,
  output logic             PREADY,
  input  logic [WIDTH-1:0] inPort,
  output logic             irq
);

  // APB handshake: IDLE covers the setup phase, WAIT is the single wait
  // state, DONE is the cycle in which PREADY is presented.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    REG_IDR  = 2'd0,
    REG_RISE = 2'd1,
    REG_FALL = 2'd2,
    REG_ISR  = 2'd3
  } reg_e;

  // ---------------------------------------------------------------------------
  // Declarations
  // ---------------------------------------------------------------------------
  state_e           state_q, state_d;
  logic             pready_q, pready_d;
  logic [31:0]      prdata_q, prdata_d;

  logic [WIDTH-1:0] s1_q, s1_d;
  logic [WIDTH-1:0] s2_q, s2_d;
  logic [WIDTH-1:0] s3_q, s3_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] isr_q, isr_d;

  logic             commit;      // WAIT->DONE edge: the transfer takes effect
  logic             wr_commit;
  logic             rd_commit;
  reg_e             reg_sel;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] edge_set;
  logic [WIDTH-1:0] w1c_clr;
  logic [WIDTH-1:0] rd_word;

  // Address bits outside [3:2] and write-data bits above the register width
  // carry no meaning for this block; fold them into one sink signal.
  logic             unused_bus_bits;
  assign unused_bus_bits = ^{PADDR[31:4], PADDR[1:0], PWDATA};

  assign reg_sel = reg_e'(PADDR[3:2]);
  assign wdata   = PWDATA[WIDTH-1:0];

  // ---------------------------------------------------------------------------
  // APB handshake FSM: next state and commit strobe
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in an always_comb gets a default at the top of
  // the block, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Setup phase (PSEL & ~PENABLE) is absorbed here; only the access
        // phase starts the wait state.
        if (PSEL && PENABLE) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A master that drops PSEL mid-transfer abandons it: no commit and
        // no PREADY pulse.
        if (!PSEL) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
          commit  = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign wr_commit = commit &  PWRITE;
  assign rd_commit = commit & ~PWRITE;

  // PREADY is registered: it is high exactly while the FSM sits in DONE.
  assign pready_d = (state_d == ST_DONE);

  // ---------------------------------------------------------------------------
  // Pin synchronizer, edge detect and register next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_d = inPort;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // s2 is the synchronized pin value, s3 is that value one cycle earlier.
  // Right after reset release a pin already high shows s2=1, s3=0 for one
  // cycle; it only latches if RISE_EN was set in time.
  assign rise     =  s2_q & ~s3_q;
  assign fall     = ~s2_q &  s3_q;
  assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);

  assign w1c_clr  = (wr_commit && (reg_sel == REG_ISR)) ? wdata : '0;

  always_comb begin
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    if (wr_commit && (reg_sel == REG_RISE)) begin
      rise_en_d = wdata;
    end
    if (wr_commit && (reg_sel == REG_FALL)) begin
      fall_en_d = wdata;
    end
    // Clear first, then OR in new edges: an edge on the same cycle as a
    // software clear of that bit wins, so no event is ever lost.
    isr_d = (isr_q & ~w1c_clr) | edge_set;
  end

  // ---------------------------------------------------------------------------
  // Read path: PRDATA is captured only on a read commit and held otherwise
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_word = '0;
    unique case (reg_sel)
      REG_IDR:  rd_word = s2_q;
      REG_RISE: rd_word = rise_en_q;
      REG_FALL: rd_word = fall_en_q;
      REG_ISR:  rd_word = isr_q;
      default:  rd_word = '0;
    endcase
  end

  always_comb begin
    prdata_d = prdata_q;
    if (rd_commit) begin
      // Upper bits stay zero; written this way so WIDTH = 32 needs no
      // zero-length replication.
      prdata_d              = '0;
      prdata_d[WIDTH-1:0]   = rd_word;
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential blocks use non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state_q  <= ST_IDLE;
      pready_q <= 1'b0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      pready_q <= pready_d;
      prdata_q <= prdata_d;
    end
  end

  // NOTE: the synchronizer and the software-visible registers are all reset,
  // so a pin that is high at release is seen as a fresh 0->1 transition and
  // the block never exposes stale status after reset.
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      isr_q     <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      isr_q     <= isr_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign PRDATA = prdata_q;
  assign PREADY = pready_q;
  assign irq    = |isr_q;

endmodule

// File: tb/tb_gpi_periph.sv
// -----------------------------------------------------------------------------
// tb_gpi_periph -- self-checking bench for gpi_periph (WIDTH = 8).
//
// The reference model keeps a short history of the pin values seen at each
// clock edge and derives IDR and edge events from it, plus plain variables for
// the enable and status registers, updated at transfer granularity by the APB
// tasks. Directed steps cover the documented scenarios; a randomized section
// then mixes pin activity with random register accesses.
// -----------------------------------------------------------------------------
module tb_gpi_periph;

  localparam int W = 8;

  logic          PCLK = 1'b0;
  logic          PRESET;
  logic [31:0]   PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PENABLE;
  logic          PSEL;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic [W-1:0]  inPort;
  logic          irq;

  int checks = 0;
  int errors = 0;

  gpi_periph #(.WIDTH(W)) dut (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .PADDR   (PADDR),
    .PWDATA  (PWDATA),
    .PWRITE  (PWRITE),
    .PENABLE (PENABLE),
    .PSEL    (PSEL),
    .PRDATA  (PRDATA),
    .PREADY  (PREADY),
    .inPort  (inPort),
    .irq     (irq)
  );

  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before 200000 ns");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  // hist[0] is the pin value sampled at the latest edge, hist[1] the one
  // before (what software sees as IDR), hist[2] the one before that.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_rise, m_fall, m_isr;
  logic [31:0]  m_prdata;
  bit           pend_wr;
  logic [1:0]   pend_sel;
  logic [31:0]  pend_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h required 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist = {};
    repeat (3) hist.push_front('0);
    m_rise   = '0;
    m_fall   = '0;
    m_isr    = '0;
    m_prdata = '0;
    pend_wr  = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] sel);
    logic [31:0] v;
    v = '0;
    case (sel)
      2'd0: v[W-1:0] = hist[1];
      2'd1: v[W-1:0] = m_rise;
      2'd2: v[W-1:0] = m_fall;
      default: v[W-1:0] = m_isr;
    endcase
    return v;
  endfunction

  // Advance one clock edge and update the model. A pin went from a to b
  // between history entries; the status register learns of it one edge
  // after it reaches IDR.
  task automatic tick();
    logic [W-1:0] smp, set_bits, clr_bits;
    smp      = inPort;
    set_bits = (m_rise & hist[1] & ~hist[2]) | (m_fall & ~hist[1] & hist[2]);
    clr_bits = '0;
    @(posedge PCLK);
    if (pend_wr) begin
      case (pend_sel)
        2'd1: m_rise = pend_data[W-1:0];
        2'd2: m_fall = pend_data[W-1:0];
        2'd3: clr_bits = pend_data[W-1:0];
        default: ;
      endcase
    end
    m_isr = (m_isr & ~clr_bits) | set_bits;
    hist.push_front(smp);
    void'(hist.pop_back());
    pend_wr = 1'b0;
    #1;
    check("irq", {31'b0, irq}, {31'b0, |m_isr});
  endtask

  // ---------------------------------------------------------------------------
  // APB phases
  // ---------------------------------------------------------------------------
  task automatic apb_setup(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    PWDATA  = data;
    tick();
    check("setup_pready", {31'b0, PREADY}, 32'd0);
  endtask

  task automatic apb_access();
    PENABLE = 1'b1;
    tick();
    check("wait_pready", {31'b0, PREADY}, 32'd0);
  endtask

  task automatic apb_commit();
    logic [31:0] exp;
    exp       = PWRITE ? m_prdata : model_read(PADDR[3:2]);
    pend_wr   = PWRITE;
    pend_sel  = PADDR[3:2];
    pend_data = PWDATA;
    tick();
    m_prdata = exp;
    check("done_pready", {31'b0, PREADY}, 32'd1);
    check("done_prdata", PRDATA, exp);
  endtask

  task automatic apb_finish();
    tick();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    check("idle_pready", {31'b0, PREADY}, 32'd0);
    check("hold_prdata", PRDATA, m_prdata);
  endtask

  task automatic apb(input bit wr, input logic [31:0] addr, input logic [31:0] data);
    apb_setup(wr, addr, data);
    apb_access();
    apb_commit();
    apb_finish();
  endtask

  // Called #1 after a clock edge: asserts reset, checks the outputs before
  // any further edge, and releases reset well before the next edge.
  task automatic do_reset();
    PRESET  = 1'b0;
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    #1;
    check("rst_pready", {31'b0, PREADY}, 32'd0);
    check("rst_prdata", PRDATA, 32'd0);
    check("rst_irq", {31'b0, irq}, 32'd0);
    model_reset();
    #1;
    PRESET = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    logic [31:0] raddr, rdata;
    bit          rwr;

    PRESET  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    PWRITE  = 1'b0;
    PENABLE = 1'b0;
    PSEL    = 1'b0;
    inPort  = '0;
    model_reset();
    repeat (2) @(posedge PCLK);
    #1;
    do_reset();

    // Pins 0xA5 read back through IDR with one wait state.
    inPort = 8'hA5;
    repeat (3) tick();
    apb(1'b0, 32'h0, 32'h0);
    check("idr_a5", PRDATA, 32'h0000_00A5);

    // Rising edge on pin 0: status appears two edges after the change edge.
    inPort = 8'h00;
    repeat (3) tick();
    apb(1'b1, 32'h4, 32'h1);
    inPort = 8'h01;
    tick();
    check("irq_edge_k", {31'b0, irq}, 32'd0);
    tick();
    check("irq_edge_k1", {31'b0, irq}, 32'd0);
    tick();
    check("irq_edge_k2", {31'b0, irq}, 32'd1);
    apb(1'b0, 32'hC, 32'h0);
    check("isr_rise0", PRDATA, 32'h0000_0001);
    apb(1'b1, 32'hC, 32'h1);
    check("irq_cleared", {31'b0, irq}, 32'd0);
    apb(1'b0, 32'hC, 32'h0);
    check("isr_cleared", PRDATA, 32'h0);

    // Falling edge on pin 7 collides with a W1C of the same bit.
    apb(1'b1, 32'h4, 32'h0);
    inPort = 8'h80;
    repeat (4) tick();
    apb(1'b1, 32'h8, 32'h80);
    inPort = 8'h00;
    apb(1'b1, 32'hC, 32'h80);
    check("irq_set_wins", {31'b0, irq}, 32'd1);
    apb(1'b0, 32'hC, 32'h0);
    check("isr_set_wins", PRDATA, 32'h0000_0080);
    apb(1'b1, 32'hC, 32'hFF);
    apb(1'b1, 32'h8, 32'h0);

    // IDR ignores writes; enable registers drop bits above WIDTH-1.
    inPort = 8'h5A;
    repeat (3) tick();
    apb(1'b1, 32'h0, 32'hFFFF_FFFF);
    apb(1'b0, 32'h0, 32'h0);
    check("idr_ro", PRDATA, 32'h0000_005A);
    apb(1'b1, 32'h4, 32'hFFFF_FF3C);
    apb(1'b0, 32'h4, 32'h0);
    check("rise_en_trunc", PRDATA, 32'h0000_003C);

    // Abandoned write: PSEL drops in the wait state.
    apb(1'b1, 32'h4, 32'h0);
    apb_setup(1'b1, 32'h4, 32'hFF);
    apb_access();
    PSEL    = 1'b0;
    PENABLE = 1'b0;
    tick();
    check("abort_pready0", {31'b0, PREADY}, 32'd0);
    tick();
    check("abort_pready1", {31'b0, PREADY}, 32'd0);
    apb(1'b0, 32'h4, 32'h0);
    check("abort_rise_en", PRDATA, 32'h0);

    // Reset in the wait state with ISR = 0x0F.
    apb(1'b1, 32'h4, 32'h0F);
    inPort = 8'h00;
    repeat (4) tick();
    inPort = 8'h0F;
    repeat (4) tick();
    check("irq_before_rst", {31'b0, irq}, 32'd1);
    apb(1'b0, 32'hC, 32'h0);
    check("isr_0f", PRDATA, 32'h0000_000F);
    apb_setup(1'b1, 32'h8, 32'hFF);
    apb_access();
    do_reset();
    apb(1'b0, 32'hC, 32'h0);
    check("isr_after_rst", PRDATA, 32'h0);
    apb(1'b0, 32'h8, 32'h0);
    check("fall_en_after_rst", PRDATA, 32'h0);

    // Reset in DONE clears PREADY and PRDATA; pins stay high through it.
    inPort = 8'hFF;
    apb_setup(1'b0, 32'h0, 32'h0);
    apb_access();
    apb_commit();
    do_reset();

    // Pins high at release, enable written later: nothing latches.
    repeat (5) tick();
    apb(1'b1, 32'h4, 32'hFF);
    repeat (3) tick();
    check("no_retro_irq", {31'b0, irq}, 32'd0);
    apb(1'b0, 32'hC, 32'h0);
    check("no_retro_isr", PRDATA, 32'h0);

    // Randomized mix of pin activity and register accesses.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 2) == 0) inPort = W'($urandom());
      repeat ($urandom_range(0, 2)) begin
        tick();
        if ($urandom_range(0, 3) == 0) inPort = W'($urandom());
      end
      raddr      = $urandom();
      raddr[3:2] = 2'($urandom_range(0, 3));
      rwr        = ($urandom_range(0, 1) == 1);
      rdata      = $urandom();
      apb(rwr, raddr, rdata);
      if (!rwr) check("rand_read", PRDATA, m_prdata);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
